// File: rtl/calc_pkg.sv
// Shared constants, state/key encodings and fixed-point helpers for the calculator controller.
package calc_pkg;

  localparam int NUM_DIGITS = 7;
  localparam int FIXP_SCALE = 10000;
  localparam logic [2:0] DP_MAX = 3'd4;

  localparam logic [2:0] DISP_IN1   = 3'd0;
  localparam logic [2:0] DISP_OPSEL = 3'd1;
  localparam logic [2:0] DISP_IN2   = 3'd2;
  localparam logic [2:0] DISP_RES   = 3'd3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IN1, S_CONV1, S_OPSEL, S_IN2, S_CONV2, S_WAIT_ALU, S_RES
  } fsm_t;

  typedef enum logic [3:0] {
    K_NONE, K_CLR, K_OK, K_NEG, K_DP, K_UP, K_DOWN, K_LEFT, K_RIGHT
  } key_t;

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

  function automatic logic [63:0] mul10(input logic [63:0] x);
    return (x << 3) + (x << 1);
  endfunction

  // Shift-add form of x*FIXP_SCALE: 8192+1024+512+256+16.
  function automatic logic [63:0] to_fixp(input logic [63:0] x);
    return (x << 13) + (x << 10) + (x << 9) + (x << 8) + (x << 4);
  endfunction

endpackage

// File: rtl/calc_ctrl_bcd_to_bin.sv
// Sequential 7-digit BCD to binary converter: MSD-first x10 accumulate, x10 scale by (4-dp), optional negate.
module bcd_to_bin
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  bcd_t        digits,
  input  logic [2:0]  dp,
  input  logic        neg,
  output logic        busy,
  output logic        done,
  output logic [63:0] mag,
  output logic [63:0] fix
);

  bcd_t        r_dig;
  logic [2:0]  r_dp;
  logic        r_neg;
  logic [3:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mag;
  logic [63:0] r_fix;
  logic        r_busy;
  logic        r_done;

  logic [2:0]  w_dp_clamp;
  logic [3:0]  w_end;
  logic [2:0]  w_idx;
  logic [63:0] w_digit;
  logic [63:0] w_acc_next;

  assign w_dp_clamp = (r_dp > DP_MAX) ? DP_MAX : r_dp;
  // Cycles 0..6 accumulate, 7..w_end-1 scale, w_end is the negate/finish cycle.
  assign w_end      = 4'd11 - {1'b0, w_dp_clamp};
  assign w_idx      = (r_cnt < 4'd7) ? (3'd6 - r_cnt[2:0]) : 3'd0;
  assign w_digit    = {60'd0, r_dig[w_idx]};
  assign w_acc_next = mul10(r_acc) + w_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig  <= '0;
      r_dp   <= '0;
      r_neg  <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mag  <= '0;
      r_fix  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_dig  <= digits;
        r_dp   <= dp;
        r_neg  <= neg;
        r_cnt  <= '0;
        r_acc  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt < 4'd7) begin
          r_acc <= w_acc_next;
          if (r_cnt == 4'd6) r_mag <= w_acc_next;
        end else if (r_cnt < w_end) begin
          r_acc <= mul10(r_acc);
        end else begin
          r_fix  <= r_neg ? (~r_acc + 64'd1) : r_acc;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign mag  = r_mag;
  assign fix  = r_fix;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: operand editing, BCD conversion, ALU handshake, display status.
// Optional cursor blink counter enabled by defining CALC_BLINK_EN.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_dp,
  input  logic        key_neg,
  input  logic        key_ok,
  input  logic        key_clr,
  output logic        alu_start,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  input  logic        alu_done,
  input  logic [63:0] alu_result,
  input  logic        alu_err,
  output logic [2:0]  state,
  output logic [63:0] operand1,
  output logic [63:0] operand2,
  output logic [63:0] result,
  output logic        err,
  output logic [1:0]  operation,
  output logic [2:0]  digit_pos,
  output logic [2:0]  decimal_pos1,
  output logic [2:0]  decimal_pos2,
  output logic        is_negative1,
  output logic        is_negative2,
  output logic        blink_state
);

  fsm_t        r_state, w_state_nxt;
  bcd_t        r_dig1, r_dig2;
  logic [2:0]  r_dp1, r_dp2;
  logic        r_neg1, r_neg2;
  logic [2:0]  r_pos;
  logic [1:0]  r_op;
  logic [63:0] r_operand1, r_operand2;
  logic [63:0] r_alu_a, r_alu_b;
  logic [63:0] r_result;
  logic        r_err;
  logic        r_alu_start;
  logic        r_restart;

  key_t        w_key;
  logic        w_edit_st;
  logic        w_sel2;
  logic        w_accept;
  logic        w_conv_start;
  bcd_t        w_dig_act, w_dig_new;
  logic [2:0]  w_dp_act, w_dp_new;
  logic        w_neg_act, w_neg_new;
  logic [2:0]  w_pos_new;
  logic [3:0]  w_cur;
  logic        w_cv_busy, w_cv_done;
  logic [63:0] w_cv_mag, w_cv_fix;

  always_comb begin
    w_key = K_NONE;
    if      (key_clr)   w_key = K_CLR;
    else if (key_ok)    w_key = K_OK;
    else if (key_neg)   w_key = K_NEG;
    else if (key_dp)    w_key = K_DP;
    else if (key_up)    w_key = K_UP;
    else if (key_down)  w_key = K_DOWN;
    else if (key_left)  w_key = K_LEFT;
    else if (key_right) w_key = K_RIGHT;
  end

  assign w_edit_st = (r_state == S_IN1) || (r_state == S_IN2);
  assign w_sel2    = (r_state == S_IN2) || (r_state == S_CONV2);
  assign w_dig_act = w_sel2 ? r_dig2 : r_dig1;
  assign w_dp_act  = w_sel2 ? r_dp2  : r_dp1;
  assign w_neg_act = w_sel2 ? r_neg2 : r_neg1;
  assign w_cur     = w_dig_act[r_pos];

  // Only keys that actually change something count as accepted (they also reset the blink phase).
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      S_IN1, S_IN2: w_accept = (w_key != K_NONE) && !((w_key == K_DP) && (r_pos > DP_MAX));
      S_OPSEL:      w_accept = (w_key == K_CLR) || (w_key == K_OK) || (w_key == K_UP) || (w_key == K_DOWN);
      S_RES:        w_accept = (w_key == K_CLR) || (w_key == K_OK);
      default:      w_accept = 1'b0;
    endcase
  end

  always_comb begin
    w_dig_new = w_dig_act;
    w_dp_new  = w_dp_act;
    w_neg_new = w_neg_act;
    w_pos_new = r_pos;
    case (w_key)
      K_CLR: begin
        w_dig_new = '0;
        w_dp_new  = '0;
        w_neg_new = 1'b0;
        w_pos_new = '0;
      end
      K_NEG:   w_neg_new = ~w_neg_act;
      K_DP:    if (r_pos <= DP_MAX) w_dp_new = r_pos;
      K_UP:    w_dig_new[r_pos] = (w_cur == 4'd9) ? 4'd0 : w_cur + 4'd1;
      K_DOWN:  w_dig_new[r_pos] = (w_cur == 4'd0) ? 4'd9 : w_cur - 4'd1;
      K_LEFT:  w_pos_new = (r_pos == 3'd6) ? 3'd0 : r_pos + 3'd1;
      K_RIGHT: w_pos_new = (r_pos == 3'd0) ? 3'd6 : r_pos - 3'd1;
      default: ;
    endcase
  end

  // Edits restart the converter one cycle later, once the edited digits are in their registers.
  assign w_conv_start = r_restart || (w_edit_st && (w_key == K_OK));

  bcd_to_bin u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_conv_start),
    .digits (w_dig_act),
    .dp     (w_dp_act),
    .neg    (w_neg_act),
    .busy   (w_cv_busy),
    .done   (w_cv_done),
    .mag    (w_cv_mag),
    .fix    (w_cv_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IN1;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IN1:      if (w_key == K_OK) w_state_nxt = S_CONV1;
      S_CONV1:    if (w_cv_done) w_state_nxt = S_OPSEL;
      S_OPSEL: begin
        if      (w_key == K_CLR) w_state_nxt = S_IN1;
        else if (w_key == K_OK)  w_state_nxt = S_IN2;
      end
      S_IN2:      if (w_key == K_OK) w_state_nxt = S_CONV2;
      S_CONV2:    if (w_cv_done) w_state_nxt = S_WAIT_ALU;
      S_WAIT_ALU: if (alu_done) w_state_nxt = S_RES;
      S_RES:      if ((w_key == K_OK) || (w_key == K_CLR)) w_state_nxt = S_IN1;
      default:    w_state_nxt = S_IN1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig1 <= '0; r_dig2 <= '0;
      r_dp1  <= '0; r_dp2  <= '0;
      r_neg1 <= 1'b0; r_neg2 <= 1'b0;
      r_pos  <= '0;
      r_op   <= OP_ADD;
      r_operand1 <= '0; r_operand2 <= '0;
      r_alu_a <= '0; r_alu_b <= '0;
      r_result <= '0;
      r_err <= 1'b0;
      r_alu_start <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_restart   <= 1'b0;
      case (r_state)
        S_IN1, S_IN2: begin
          if (w_accept && (w_key != K_OK)) begin
            r_restart <= 1'b1;
            r_pos     <= w_pos_new;
            if (w_sel2) begin
              r_dig2 <= w_dig_new; r_dp2 <= w_dp_new; r_neg2 <= w_neg_new;
            end else begin
              r_dig1 <= w_dig_new; r_dp1 <= w_dp_new; r_neg1 <= w_neg_new;
            end
          end
        end
        S_OPSEL: begin
          case (w_key)
            K_UP:   r_op <= r_op + 2'd1;
            K_DOWN: r_op <= r_op - 2'd1;
            K_OK: begin
              r_dig2 <= '0; r_dp2 <= '0; r_neg2 <= 1'b0;
              r_pos  <= '0;
              r_operand2 <= '0;
            end
            default: ;
          endcase
        end
        S_WAIT_ALU: begin
          if (alu_done) begin
            r_result <= alu_result;
            r_err    <= alu_err;
          end
        end
        S_RES: begin
          if ((w_key == K_OK) || (w_key == K_CLR)) begin
            r_dig1 <= '0; r_dig2 <= '0;
            r_dp1  <= '0; r_dp2  <= '0;
            r_neg1 <= 1'b0; r_neg2 <= 1'b0;
            r_pos  <= '0;
            r_op   <= OP_ADD;
            r_operand1 <= '0; r_operand2 <= '0;
            r_alu_a <= '0; r_alu_b <= '0;
            r_result <= '0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_cv_done) begin
        if (w_sel2) begin
          r_operand2 <= to_fixp(w_cv_mag);
          if (r_state == S_CONV2) begin
            r_alu_b     <= w_cv_fix;
            r_alu_start <= 1'b1;
          end
        end else begin
          r_operand1 <= to_fixp(w_cv_mag);
          if (r_state == S_CONV1) r_alu_a <= w_cv_fix;
        end
      end
    end
  end

  always_comb begin
    state = DISP_IN1;
    case (r_state)
      S_IN1, S_CONV1:              state = DISP_IN1;
      S_OPSEL:                     state = DISP_OPSEL;
      S_IN2, S_CONV2, S_WAIT_ALU:  state = DISP_IN2;
      S_RES:                       state = DISP_RES;
      default:                     state = DISP_IN1;
    endcase
  end

`ifdef CALC_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_accept) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == 32'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign blink_state = r_blink;
`else
  assign blink_state = 1'b1;
`endif

  assign alu_start    = r_alu_start;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign operand1     = r_operand1;
  assign operand2     = r_operand2;
  assign result       = r_result;
  assign err          = r_err;
  assign operation    = r_op;
  assign digit_pos    = r_pos;
  assign decimal_pos1 = r_dp1;
  assign decimal_pos2 = r_dp2;
  assign is_negative1 = r_neg1;
  assign is_negative2 = r_neg2;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the calculator: owns the INPUT1 → OP_SELECT → INPUT2 → RESULT flow. It turns single-cycle key pulses into edits of two 7-digit BCD operands and converts each operand to binary. It hands the fixed-point operands to the ALU over a start/done handshake and drives every status input of `display_driver`: state, operands, result, cursor, decimal point, sign and blink.

## Interface
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period (0.5 s at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_dp`, `key_neg`, `key_ok`, `key_clr`  in  1 each  debounced single-cycle key pulses.
- `alu_start`  out  1  one-cycle request to the ALU.
- `alu_a`, `alu_b`  out  64 each  signed fixed-point operands, value ×10000.
- `alu_done`  in  1  one-cycle completion pulse.
- `alu_result`  in  64  ALU result, valid with `alu_done`.
- `alu_err`  in  1  error flag (for example divide by zero), valid with `alu_done`.
- `state`  out  3  display state: 0 INPUT1, 1 OP_SELECT, 2 INPUT2, 3 RESULT.
- `operand1`, `operand2`  out  64 each  display form, N×10000 (N = unsigned 7-digit value).
- `result`  out  64  latched `alu_result`.
- `err`  out  1  latched `alu_err`.
- `operation`  out  2  0 add, 1 sub, 2 mul, 3 div.
- `digit_pos`  out  3  cursor position, 0 = rightmost digit, range 0..6.
- `decimal_pos1`, `decimal_pos2`  out  3 each  digits right of the decimal point, 0..4.
- `is_negative1`, `is_negative2`  out  1 each  operand sign.
- `blink_state`  out  1  0 = blank the cursor digit.

## Operation
- Internal FSM states: IN1, CONV1, OPSEL, IN2, CONV2, WAIT_ALU, RES.
- `state` output mapping:
  - IN1 and CONV1 → 0.
  - OPSEL → 1.
  - IN2, CONV2 and WAIT_ALU → 2.
  - RES → 3.
- Key handling in IN1 and IN2. The keys edit the active operand: 7 BCD digits, dp and sign.
  - `key_up`/`key_down`: digit at `digit_pos` ±1 mod 10 (9→0, 0→9).
  - `key_left`: pos+1, wrapping 6→0. `key_right`: pos−1, wrapping 0→6.
  - `key_dp`: dp ← `digit_pos` if `digit_pos` ≤ 4, else ignored.
  - `key_neg`: toggles sign.
  - `key_clr`: clears digits, dp, sign and pos.
  - `key_ok`: starts a conversion and moves to CONV1 or CONV2. All keys are ignored in CONV1, CONV2 and WAIT_ALU.
- Background conversion: every edit restarts the converter. On done, `operandN` ← N×10000, computed as (N<<13)+(N<<10)+(N<<9)+(N<<8)+(N<<4).
- Conversion done in CONV1: `alu_a` ← ±N×10^(4−dp), then → OPSEL.
- Conversion done in CONV2: `alu_b` is latched, `alu_start` pulses, then → WAIT_ALU.
- OPSEL:
  - `key_up`/`key_down` cycle `operation` mod 4.
  - `key_ok` → IN2 with operand2 fields and `digit_pos` cleared.
  - `key_clr` → IN1 with operand1 kept.
- WAIT_ALU: on `alu_done`, latch `result` and `err`, then → RES.
- RES: `key_ok` or `key_clr` → IN1 with all operand fields, `result`, `err` and `operation` cleared.
- Key priority when several pulses arrive in one cycle: `clr` > `ok` > `neg` > `dp` > `up` > `down` > `left` > `right`. Only one key is acted on.
- `alu_done` outside WAIT_ALU is ignored.

## Timing
- Reset values:
  - `state` 0 (IN1).
  - All 64-bit outputs 0.
  - `operation`, `digit_pos` and dp outputs 0.
  - Signs 0, `err` 0, `alu_start` 0, `blink_state` 1, blink counter 0.
- Reset mid-operation aborts the conversion and any ALU wait. A late `alu_done` after reset is ignored.
- Key edits update the digit, pos, dp and sign outputs in the cycle after the pulse.
- Converter latency:
  - Accumulate phase: 7 cycles, acc ← acc×10 + digit, most-significant digit first.
  - Scale phase: 4−dp further ×10 cycles.
  - One final cycle for the optional two's-complement negate.
  - Total ≤ 12 cycles.
  - A restart while busy aborts the run and begins again from cycle 0.
- `alu_start` is high for exactly one cycle: the cycle after CONV2 completes, with `alu_a`/`alu_b` stable until RES is left.
- Blink counter:
  - Counts 0..BLINK_DIV−1 and toggles `blink_state` on wrap.
  - Any accepted edit key zeroes the counter and forces `blink_state` to 1 next cycle.

## Configuration
- `CALC_BLINK_EN` defined: blink counter and toggling as above.
- `CALC_BLINK_EN` undefined: no counter; `blink_state` is constant 1, so the cursor digit is always shown.

## Structure
- Shared package `calc_pkg` holds:
  - Display-state codes 0..3 and the operation codes.
  - The FIXP_SCALE = 10000 constant and NUM_DIGITS = 7.
  - The maximum dp value, 4.
- Sub-module `bcd_to_bin`:
  - Inputs: `start`, 7×4-bit digits, dp, neg.
  - Outputs: `busy`, one-cycle `done`, 64-bit `mag` (N) and `fix` (±N×10^(4−dp)).
  - Contains the sequential ×10 loop and its cycle counter.

## Test plan
- Reset, then 3× `key_up` at pos 0 → `operand1`=30000 within 12 cycles; then `key_down` ×4 → digit wraps to 9, `operand1`=90000.
- 7× `key_left` from pos 0 → `digit_pos` sequence 1..6,0; `key_right` at pos 0 → 6. With pos 5, `key_dp` → `decimal_pos1` unchanged.
- Enter digits 1,2,5 (N=125), set dp at pos 1, press `key_neg`, then `key_ok`:
  - `alu_a` = −125000 (two's complement).
  - `state` passes 0 → 1.
- In OPSEL, `key_down` from 0 → `operation`=3; `key_up` → 0.
- Full flow 7 `ok` add 3 `ok`:
  - Single-cycle `alu_start` with `alu_a`=70000, `alu_b`=30000.
  - Respond `alu_done`, `alu_result`=100000 → `state`=3, `result`=100000, `err`=0.
  - `key_ok` → `state`=0, all outputs at reset values.
- Assert `rst` during WAIT_ALU, then pulse `alu_done` → outputs at reset values and `state` stays 0.
- `alu_done` with `alu_err`=1 → `err`=1 in RES.
